inverse_park: RTL and testbench

- Inverse Park transform: rotates a d/q vector back to the stationary alpha/beta frame using electrical angle theta.
- Sits between the current/voltage controllers and the modulator (SVPWM / inverse Clarke) in the transform acceleration unit.
- Uses a single time-multiplexed signed multiplier plus an FSM, with valid/ready handshakes on both sides.
- alpha = cos·d − sin·q; beta = sin·d + cos·q.

---
 rtl/inverse_park_pkg.sv | 30 +++
 rtl/inverse_park_trig.sv | 72 +++++++
 rtl/inverse_park.sv | 137 +++++++++++++
 tb/tb_inverse_park.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inverse_park_pkg.sv
// Shared widths, saturation limits and FSM encoding for the inverse Park transform.
// Also holds the scale-and-limit helper used on the accumulator outputs.
package inverse_park_pkg;

    localparam int DATA_W     = 18;
    localparam int TRIG_W     = 16;
    localparam int THETA_W    = 16;
    localparam int FRAC_SHIFT = 15;
    localparam int PROD_W     = DATA_W + TRIG_W;
    localparam int ACC_W      = PROD_W + 1;

    localparam int SAT_MAX = 131071;
    localparam int SAT_MIN = -131072;

    typedef enum logic [1:0] {IDLE, TRIG, MAC, DONE} state_t;

    // Drop the Q1.15 fraction (floor), then clamp or wrap to 18 bits.
    function automatic logic signed [DATA_W-1:0] sat18(input logic signed [ACC_W-1:0] acc,
                                                       input logic sat);
        logic signed [ACC_W-1:0] sh;
        sh = acc >>> FRAC_SHIFT;
        if (sat && (sh > ACC_W'(SAT_MAX)))
            return DATA_W'(SAT_MAX);
        else if (sat && (sh < ACC_W'(SAT_MIN)))
            return DATA_W'(SAT_MIN);
        else
            return sh[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/inverse_park_trig.sv
// Sin/cos lookup: 64 angles per turn from a 17-entry quarter-wave table (Q1.15),
// followed by a LATENCY-deep register pipeline.
module inverse_park_trig
    import inverse_park_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [THETA_W-1:0]       theta,
    output logic signed [TRIG_W-1:0] sin_val,
    output logic signed [TRIG_W-1:0] cos_val
);

    logic [5:0]                          sin_idx;
    logic [5:0]                          cos_idx;
    logic [LATENCY-1:0][TRIG_W-1:0]      sin_pipe;
    logic [LATENCY-1:0][TRIG_W-1:0]      cos_pipe;

    function automatic logic [TRIG_W-2:0] quarter(input logic [4:0] k);
        case (k)
            5'd0:  return 15'd0;
            5'd1:  return 15'd3212;
            5'd2:  return 15'd6393;
            5'd3:  return 15'd9512;
            5'd4:  return 15'd12539;
            5'd5:  return 15'd15446;
            5'd6:  return 15'd18204;
            5'd7:  return 15'd20787;
            5'd8:  return 15'd23170;
            5'd9:  return 15'd25329;
            5'd10: return 15'd27245;
            5'd11: return 15'd28898;
            5'd12: return 15'd30273;
            5'd13: return 15'd31356;
            5'd14: return 15'd32137;
            5'd15: return 15'd32609;
            default: return 15'd32767;
        endcase
    endfunction

    // idx[5:4] is the quadrant; odd quadrants read the table mirrored.
    function automatic logic [TRIG_W-1:0] sine(input logic [5:0] idx);
        logic [4:0]        k;
        logic [TRIG_W-1:0] mag;
        k   = idx[4] ? (5'd16 - {1'b0, idx[3:0]}) : {1'b0, idx[3:0]};
        mag = {1'b0, quarter(k)};
        return idx[5] ? (~mag + 1'b1) : mag;
    endfunction

    // Round theta to the nearest of the 64 table angles; overflow wraps to angle 0.
    assign sin_idx = 6'((theta + THETA_W'(512)) >> 10);
    assign cos_idx = sin_idx + 6'd16;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sin_pipe <= '0;
            cos_pipe <= '0;
        end else begin
            sin_pipe[0] <= sine(sin_idx);
            cos_pipe[0] <= sine(cos_idx);
            for (int i = 1; i < LATENCY; i++) begin
                sin_pipe[i] <= sin_pipe[i-1];
                cos_pipe[i] <= cos_pipe[i-1];
            end
        end
    end

    assign sin_val = $signed(sin_pipe[LATENCY-1]);
    assign cos_val = $signed(cos_pipe[LATENCY-1]);

endmodule

// File: rtl/inverse_park.sv
// Inverse Park transform (d/q -> alpha/beta) with one shared signed multiplier,
// sequenced by an IDLE/TRIG/MAC/DONE FSM with valid/ready on both sides.
module inverse_park
    import inverse_park_pkg::*;
#(
    parameter int TRIG_LATENCY = 2,
    parameter bit SATURATE     = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [THETA_W-1:0]       theta,
    input  logic signed [DATA_W-1:0] d,
    input  logic signed [DATA_W-1:0] q,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] alpha,
    output logic signed [DATA_W-1:0] beta,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int WAIT_W = (TRIG_LATENCY > 1) ? $clog2(TRIG_LATENCY) : 1;

    state_t                     state;
    logic [THETA_W-1:0]         theta_r;
    logic signed [DATA_W-1:0]   d_r;
    logic signed [DATA_W-1:0]   q_r;
    logic signed [TRIG_W-1:0]   sin_r;
    logic signed [TRIG_W-1:0]   cos_r;
    logic [1:0]                 step;
    logic [WAIT_W-1:0]          wait_cnt;
    logic signed [ACC_W-1:0]    acc_a;
    logic signed [ACC_W-1:0]    acc_b;

    logic [THETA_W-1:0]         trig_theta;
    logic signed [TRIG_W-1:0]   sin_val;
    logic signed [TRIG_W-1:0]   cos_val;
    logic signed [TRIG_W-1:0]   mul_a;
    logic signed [DATA_W-1:0]   mul_b;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_b_sum;
    logic                       accept;

    assign in_ready = reset && (state == IDLE);
    assign accept   = in_valid && in_ready;

    // Feeding the raw input while idle starts the trig pipeline on the accept edge,
    // so its outputs are settled by the time the wait counter expires.
    assign trig_theta = (state == IDLE) ? theta : theta_r;

    inverse_park_trig #(.LATENCY(TRIG_LATENCY)) u_trig (
        .clock   (clock),
        .reset   (reset),
        .theta   (trig_theta),
        .sin_val (sin_val),
        .cos_val (cos_val)
    );

    always_comb begin
        mul_a = cos_r;
        mul_b = d_r;
        case (step)
            2'd0: begin mul_a = cos_r; mul_b = d_r; end
            2'd1: begin mul_a = sin_r; mul_b = q_r; end
            2'd2: begin mul_a = sin_r; mul_b = d_r; end
            default: begin mul_a = cos_r; mul_b = q_r; end
        endcase
    end

    assign prod      = mul_a * mul_b;
    assign prod_ext  = ACC_W'(prod);
    assign acc_b_sum = acc_b + prod_ext;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            theta_r   <= '0;
            d_r       <= '0;
            q_r       <= '0;
            sin_r     <= '0;
            cos_r     <= '0;
            step      <= '0;
            wait_cnt  <= '0;
            acc_a     <= '0;
            acc_b     <= '0;
            alpha     <= '0;
            beta      <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        theta_r  <= theta;
                        d_r      <= d;
                        q_r      <= q;
                        wait_cnt <= '0;
                        state    <= TRIG;
                    end
                end
                TRIG: begin
                    if (wait_cnt == WAIT_W'(TRIG_LATENCY - 1)) begin
                        sin_r <= sin_val;
                        cos_r <= cos_val;
                        step  <= '0;
                        state <= MAC;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                MAC: begin
                    step <= step + 1'b1;
                    case (step)
                        2'd0: acc_a <= prod_ext;
                        2'd1: acc_a <= acc_a - prod_ext;
                        2'd2: acc_b <= prod_ext;
                        default: begin
                            // Last product goes straight into beta on the DONE entry edge.
                            acc_b     <= acc_b_sum;
                            alpha     <= sat18(acc_a, SATURATE);
                            beta      <= sat18(acc_b_sum, SATURATE);
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    endcase
                end
                default: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inverse_park.sv
// Directed and randomized checks of inverse_park against an arithmetic reference
// that derives sin/cos from $sin/$cos rounded to Q1.15 at 64 angles per turn.
module tb_inverse_park;

    localparam int L = 2;
    localparam int N_SWEEP = 1000;

    logic               clock = 1'b0;
    logic               reset;
    logic [15:0]        theta = '0;
    logic signed [17:0] d = '0;
    logic signed [17:0] q = '0;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;
    logic               in_ready, out_valid, in_ready_w, out_valid_w;
    logic signed [17:0] alpha, beta, alpha_w, beta_w;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        int a_sat;
        int b_sat;
        int a_wrap;
        int b_wrap;
    } exp_t;

    exp_t exp_q[$];

    always #5 clock = ~clock;

    inverse_park #(.TRIG_LATENCY(L), .SATURATE(1'b1)) dut (
        .clock(clock), .reset(reset), .theta(theta), .d(d), .q(q),
        .in_valid(in_valid), .in_ready(in_ready), .alpha(alpha), .beta(beta),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    inverse_park #(.TRIG_LATENCY(L), .SATURATE(1'b0)) dut_wrap (
        .clock(clock), .reset(reset), .theta(theta), .d(d), .q(q),
        .in_valid(in_valid), .in_ready(in_ready_w), .alpha(alpha_w), .beta(beta_w),
        .out_valid(out_valid_w), .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic longint trig_ref(input int k, input bit is_cos);
        real a, v;
        a = 6.283185307179586 * real'(k) / 64.0;
        v = 32767.0 * (is_cos ? $cos(a) : $sin(a));
        return (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(0.5 - v));
    endfunction

    function automatic int ref_out(input int th, input int dd, input int qq, input bit is_beta, input bit sat);
        int k;
        longint s, c, acc, sh;
        k   = ((th + 512) / 1024) % 64;
        s   = trig_ref(k, 1'b0);
        c   = trig_ref(k, 1'b1);
        acc = is_beta ? (s * dd + c * qq) : (c * dd - s * qq);
        sh  = acc >>> 15;
        if (sat) begin
            if (sh > 131071) sh = 131071;
            else if (sh < -131072) sh = -131072;
        end else begin
            sh = sh % 262144;
            if (sh < 0) sh += 262144;
            if (sh >= 131072) sh -= 262144;
        end
        return int'(sh);
    endfunction

    function automatic exp_t model(input int th, input int dd, input int qq);
        exp_t e;
        e.a_sat  = ref_out(th, dd, qq, 1'b0, 1'b1);
        e.b_sat  = ref_out(th, dd, qq, 1'b1, 1'b1);
        e.a_wrap = ref_out(th, dd, qq, 1'b0, 1'b0);
        e.b_wrap = ref_out(th, dd, qq, 1'b1, 1'b0);
        return e;
    endfunction

    // Called just after a negedge; returns at the first negedge after the accept edge.
    task automatic send(input logic [15:0] th, input logic signed [17:0] dd, input logic signed [17:0] qq);
        int n;
        n = 0;
        theta = th; d = dd; q = qq; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("send_in_ready", in_ready, 1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clock);
            lat++;
        end
        check("wait_out_valid", out_valid, 1);
    endtask

    task automatic check_out(input string tag, input int th, input int dd, input int qq);
        exp_t e;
        e = model(th, dd, qq);
        check({tag, "_alpha"}, alpha, e.a_sat);
        check({tag, "_beta"}, beta, e.b_sat);
        check({tag, "_alpha_wrap"}, alpha_w, e.a_wrap);
        check({tag, "_beta_wrap"}, beta_w, e.b_wrap);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check("release_out_valid", out_valid, 0);
    endtask

    initial begin
        int lat, n_acc, n_sent, n_recv, cyc, bad;
        int acc_cyc[2];
        exp_t e;

        // Reset held with random traffic on the inputs
        reset = 1'b1;
        #2 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            theta = 16'($urandom); d = 18'($urandom); q = 18'($urandom);
            in_valid = 1'b1; out_ready = 1'($urandom);
        end
        @(negedge clock);
        check("rst_alpha", alpha, 0);
        check("rst_beta", beta, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        in_valid = 1'b0; out_ready = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check("post_rst_in_ready", in_ready, 1);

        // Zero angle, latency, then back-pressure
        send(16'h0000, 18'sd1000, 18'sd0);
        wait_valid(lat);
        check("latency", lat, L + 5);
        check("zero_alpha_const", alpha, 999);
        check("zero_beta_const", beta, 0);
        check_out("zero", 0, 1000, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            in_valid = 1'($urandom); theta = 16'($urandom); d = 18'($urandom); q = 18'($urandom);
            check("bp_alpha", alpha, 999);
            check("bp_beta", beta, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        release_out();
        check("hold_alpha", alpha, 999);
        check("idle_in_ready", in_ready, 1);

        // Quadrature term only
        send(16'h0000, 18'sd0, -18'sd1000);
        wait_valid(lat);
        check("quad_alpha_const", alpha, 0);
        check("quad_beta_const", beta, -1000);
        check_out("quad", 0, 0, -1000);
        release_out();

        // Saturation vs wrap at 45 degrees
        send(16'h2000, 18'sd131071, -18'sd131072);
        wait_valid(lat);
        check("sat_alpha_const", alpha, 131071);
        check("sat_beta_const", beta, -1);
        check_out("sat", 16'h2000, 131071, -131072);
        release_out();

        // Back-to-back throughput with out_ready held high
        acc_cyc[0] = 0; acc_cyc[1] = 0; n_acc = 0;
        theta = 16'h0000; d = 18'sd1000; q = 18'sd0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 40 && n_acc < 2; i++) begin
            if (in_valid && in_ready) begin
                acc_cyc[n_acc] = i;
                n_acc++;
                if (n_acc == 2) in_valid = 1'b0;
            end
            @(negedge clock);
        end
        check("period", acc_cyc[1] - acc_cyc[0], L + 6);
        repeat (20) @(negedge clock);
        out_ready = 1'b0;
        check("period_alpha", alpha, 999);

        // Reset in the middle of MAC
        send(16'h1234, 18'sd50000, -18'sd7000);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < L + 10; i++) begin
            @(negedge clock);
            if (out_valid || out_valid_w) bad++;
        end
        check("midrst_no_output", bad, 0);
        send(16'hC3A0, -18'sd90000, 18'sd45000);
        wait_valid(lat);
        check_out("after_rst", 16'hC3A0, -90000, 45000);
        release_out();

        // Random sweep with random in_valid/out_ready and a scoreboard
        n_sent = 0; n_recv = 0; cyc = 0;
        while (n_recv < N_SWEEP && cyc < 60000) begin
            @(negedge clock);
            cyc++;
            in_valid  = (n_sent < N_SWEEP) && ($urandom_range(0, 3) != 0);
            theta     = 16'($urandom);
            d         = 18'($urandom);
            q         = 18'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_valid && in_ready) begin
                exp_q.push_back(model(int'(theta), int'(d), int'(q)));
                n_sent++;
            end
            if (out_valid && out_ready) begin
                n_assert++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL sweep_dup observed=output expected=none_pending");
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sweep_alpha", alpha, e.a_sat);
                    check("sweep_beta", beta, e.b_sat);
                    check("sweep_alpha_wrap", alpha_w, e.a_wrap);
                    check("sweep_beta_wrap", beta_w, e.b_wrap);
                end
                n_recv++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("sweep_recv", n_recv, N_SWEEP);
        check("sweep_pending", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
